// File: rtl/cache_req_arbiter.sv
// Two-requester round-robin front end for cache_top: one transaction in flight at a time,
// with a response timeout and in-place rejection of illegal opcodes.
module cache_req_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic        cclk,
    input  logic        cresetn,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_req_address,
    input  logic [1:0]  m0_req_op,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_resp_valid,
    output logic [31:0] m0_resp_rdata,
    output logic        m0_resp_status,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_req_address,
    input  logic [1:0]  m1_req_op,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_resp_valid,
    output logic [31:0] m1_resp_rdata,
    output logic        m1_resp_status,

    output logic        c_req_valid,
    output logic [31:0] c_req_address,
    output logic [1:0]  c_req_op,
    output logic [31:0] c_req_wdata,
    input  logic        c_resp_valid,
    input  logic [31:0] c_resp_rdata,
    input  logic        c_resp_status
);

    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    state_e      state_q;
    logic        last_q;   // index of the last accepted requester
    logic        owner_q;  // index of the requester owning the current transaction
    logic [15:0] cnt_q;

    logic        gnt_idx;
    logic        accept;
    logic        op_legal;
    logic [31:0] sel_address;
    logic [1:0]  sel_op;
    logic [31:0] sel_wdata;

    logic        fin;
    logic        fin_owner;
    logic [31:0] fin_rdata;
    logic        fin_status;

    // On a tie the requester that was not accepted last wins.
    always_comb begin
        if (m0_req_valid && m1_req_valid) begin
            gnt_idx = ~last_q;
        end else begin
            gnt_idx = m1_req_valid;
        end
    end

    assign m0_req_ready = (state_q == StIdle) & m0_req_valid & ~gnt_idx;
    assign m1_req_ready = (state_q == StIdle) & m1_req_valid & gnt_idx;
    assign accept       = m0_req_ready | m1_req_ready;

    assign sel_address = gnt_idx ? m1_req_address : m0_req_address;
    assign sel_op      = gnt_idx ? m1_req_op      : m0_req_op;
    assign sel_wdata   = gnt_idx ? m1_req_wdata   : m0_req_wdata;
    assign op_legal    = (sel_op == OpRead) || (sel_op == OpWrite);

    // fin marks the cycle that moves into StResp and what the response will carry.
    always_comb begin
        fin        = 1'b0;
        fin_owner  = owner_q;
        fin_rdata  = 32'h0;
        fin_status = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && !op_legal) begin
                    fin        = 1'b1;
                    fin_owner  = gnt_idx;
                    fin_status = 1'b1;
                end
            end
            StReq: begin
                if (c_resp_valid) begin
                    fin        = 1'b1;
                    fin_rdata  = c_resp_rdata;
                    fin_status = c_resp_status;
                end else if (cnt_q == (TIMEOUT - 16'd1)) begin
                    fin        = 1'b1;
                    fin_status = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge cclk or negedge cresetn) begin
        if (!cresetn) begin
            state_q        <= StIdle;
            last_q         <= 1'b1;
            owner_q        <= 1'b0;
            cnt_q          <= 16'h0;
            c_req_valid    <= 1'b0;
            c_req_address  <= 32'h0;
            c_req_op       <= 2'b00;
            c_req_wdata    <= 32'h0;
            m0_resp_valid  <= 1'b0;
            m0_resp_rdata  <= 32'h0;
            m0_resp_status <= 1'b0;
            m1_resp_valid  <= 1'b0;
            m1_resp_rdata  <= 32'h0;
            m1_resp_status <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        last_q  <= gnt_idx;
                        owner_q <= gnt_idx;
                        if (op_legal) begin
                            state_q       <= StReq;
                            cnt_q         <= 16'h0;
                            c_req_valid   <= 1'b1;
                            c_req_address <= sel_address;
                            c_req_op      <= sel_op;
                            c_req_wdata   <= sel_wdata;
                        end else begin
                            state_q <= StResp;
                        end
                    end
                end
                StReq: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (fin) begin
                        state_q       <= StResp;
                        c_req_valid   <= 1'b0;
                        c_req_address <= 32'h0;
                        c_req_op      <= 2'b00;
                        c_req_wdata   <= 32'h0;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            // Response registers are loaded only on entry to StResp, so they pulse one cycle.
            m0_resp_valid  <= fin & ~fin_owner;
            m0_resp_rdata  <= (fin & ~fin_owner) ? fin_rdata : 32'h0;
            m0_resp_status <= fin & ~fin_owner & fin_status;
            m1_resp_valid  <= fin & fin_owner;
            m1_resp_rdata  <= (fin & fin_owner) ? fin_rdata : 32'h0;
            m1_resp_status <= fin & fin_owner & fin_status;
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with TIMEOUT=8: single requests, round-robin ties,
// timeout, illegal opcode, response on the last timeout cycle and reset during a request.
module tb_cache_req_arbiter;

    logic        cclk = 1'b0;
    logic        cresetn;
    logic        m0_req_valid, m1_req_valid;
    logic        m0_req_ready, m1_req_ready;
    logic [31:0] m0_req_address, m1_req_address;
    logic [1:0]  m0_req_op, m1_req_op;
    logic [31:0] m0_req_wdata, m1_req_wdata;
    logic        m0_resp_valid, m1_resp_valid;
    logic [31:0] m0_resp_rdata, m1_resp_rdata;
    logic        m0_resp_status, m1_resp_status;
    logic        c_req_valid;
    logic [31:0] c_req_address, c_req_wdata;
    logic [1:0]  c_req_op;
    logic        c_resp_valid;
    logic [31:0] c_resp_rdata;
    logic        c_resp_status;

    int n_asserts = 0;
    int n_fail    = 0;

    cache_req_arbiter #(.TIMEOUT(16'd8)) dut (
        .cclk           (cclk),
        .cresetn        (cresetn),
        .m0_req_valid   (m0_req_valid),
        .m0_req_ready   (m0_req_ready),
        .m0_req_address (m0_req_address),
        .m0_req_op      (m0_req_op),
        .m0_req_wdata   (m0_req_wdata),
        .m0_resp_valid  (m0_resp_valid),
        .m0_resp_rdata  (m0_resp_rdata),
        .m0_resp_status (m0_resp_status),
        .m1_req_valid   (m1_req_valid),
        .m1_req_ready   (m1_req_ready),
        .m1_req_address (m1_req_address),
        .m1_req_op      (m1_req_op),
        .m1_req_wdata   (m1_req_wdata),
        .m1_resp_valid  (m1_resp_valid),
        .m1_resp_rdata  (m1_resp_rdata),
        .m1_resp_status (m1_resp_status),
        .c_req_valid    (c_req_valid),
        .c_req_address  (c_req_address),
        .c_req_op       (c_req_op),
        .c_req_wdata    (c_req_wdata),
        .c_resp_valid   (c_resp_valid),
        .c_resp_rdata   (c_resp_rdata),
        .c_resp_status  (c_resp_status)
    );

    always #5 cclk = ~cclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge cclk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        cresetn = 1'b0;
        tick();
        tick();
        cresetn = 1'b1;
        tick();
    endtask

    logic [31:0] all_out;
    int          n_creq;
    logic        seen;

    initial begin
        cresetn        = 1'b0;
        m0_req_valid   = 1'b0;
        m1_req_valid   = 1'b0;
        m0_req_address = 32'h0;
        m1_req_address = 32'h0;
        m0_req_op      = 2'b00;
        m1_req_op      = 2'b00;
        m0_req_wdata   = 32'h0;
        m1_req_wdata   = 32'h0;
        c_resp_valid   = 1'b0;
        c_resp_rdata   = 32'h0;
        c_resp_status  = 1'b0;
        tick();
        all_out = {24'h0, c_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid,
                   m1_resp_valid, m0_resp_status, m1_resp_status, 1'b0};
        check("reset_ctrl", all_out, 32'h0);
        check("reset_data", m0_resp_rdata | m1_resp_rdata | c_req_address | c_req_wdata, 32'h0);
        do_reset();

        // m0 read alone, cache answers on the third request cycle
        m0_req_valid = 1'b1; m0_req_op = 2'b01; m0_req_address = 32'h100;
        settle();
        check("t1_ready", {30'h0, m1_req_ready, m0_req_ready}, 32'h1);
        tick();
        m0_req_valid = 1'b0;
        check("t1_creq_valid", {31'h0, c_req_valid}, 32'h1);
        check("t1_creq_addr", c_req_address, 32'h100);
        check("t1_creq_op", {30'h0, c_req_op}, 32'h1);
        tick();
        check("t1_creq_hold", c_req_address, 32'h100);
        tick();
        c_resp_valid = 1'b1; c_resp_rdata = 32'hDEADBEEF; c_resp_status = 1'b0;
        tick();
        c_resp_valid = 1'b0; c_resp_rdata = 32'h0;
        check("t1_resp_valid", {31'h0, m0_resp_valid}, 32'h1);
        check("t1_resp_rdata", m0_resp_rdata, 32'hDEADBEEF);
        check("t1_resp_status", {31'h0, m0_resp_status}, 32'h0);
        check("t1_m1_quiet", {m1_resp_rdata[30:0], m1_resp_valid | m1_resp_status}, 32'h0);
        check("t1_creq_off", {31'h0, c_req_valid}, 32'h0);
        tick();
        check("t1_resp_pulse", {31'h0, m0_resp_valid}, 32'h0);
        check("t1_rdata_clear", m0_resp_rdata, 32'h0);

        // both requesters held valid after reset: m0, m1, m0, m1
        do_reset();
        m0_req_valid = 1'b1; m0_req_op = 2'b01; m0_req_address = 32'h200;
        m1_req_valid = 1'b1; m1_req_op = 2'b01; m1_req_address = 32'h300;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("t2_grant%0d", i), {30'h0, m1_req_ready, m0_req_ready},
                  (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check($sformatf("t2_addr%0d", i), c_req_address,
                  (i % 2 == 0) ? 32'h200 : 32'h300);
            c_resp_valid = 1'b1; c_resp_rdata = 32'hA0 + i;
            tick();
            c_resp_valid = 1'b0;
            check($sformatf("t2_resp%0d", i), {30'h0, m1_resp_valid, m0_resp_valid},
                  (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
        end
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;

        // m1 write, cache silent: eight request cycles then an error response
        m1_req_valid = 1'b1; m1_req_op = 2'b10; m1_req_address = 32'h400;
        m1_req_wdata = 32'h55AA55AA;
        tick();
        m1_req_valid = 1'b0;
        check("t3_creq_op", {30'h0, c_req_op}, 32'h2);
        check("t3_creq_wdata", c_req_wdata, 32'h55AA55AA);
        n_creq = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (c_req_valid) n_creq++;
            if (m1_resp_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t3_resp_seen", {31'h0, seen}, 32'h1);
        check("t3_creq_cycles", n_creq, 32'd8);
        check("t3_status", {31'h0, m1_resp_status}, 32'h1);
        check("t3_rdata", m1_resp_rdata, 32'h0);
        check("t3_m0_quiet", {31'h0, m0_resp_valid}, 32'h0);
        tick();

        // illegal opcode is answered without touching the cache
        m0_req_valid = 1'b1; m0_req_op = 2'b11; m0_req_address = 32'h500;
        settle();
        check("t4_ready", {31'h0, m0_req_ready}, 32'h1);
        check("t4_no_early_resp", {31'h0, m0_resp_valid}, 32'h0);
        tick();
        m0_req_valid = 1'b0;
        check("t4_no_creq", {31'h0, c_req_valid}, 32'h0);
        check("t4_resp_valid", {31'h0, m0_resp_valid}, 32'h1);
        check("t4_status", {31'h0, m0_resp_status}, 32'h1);
        check("t4_rdata", m0_resp_rdata, 32'h0);
        tick();
        check("t4_done", {31'h0, m0_resp_valid | c_req_valid}, 32'h0);

        // response arriving on the final timeout cycle wins
        m0_req_valid = 1'b1; m0_req_op = 2'b01; m0_req_address = 32'h600;
        tick();
        m0_req_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("t5_still_req", {31'h0, c_req_valid}, 32'h1);
        c_resp_valid = 1'b1; c_resp_rdata = 32'hCAFEF00D; c_resp_status = 1'b0;
        tick();
        c_resp_valid = 1'b0; c_resp_rdata = 32'h0;
        check("t5_resp_valid", {31'h0, m0_resp_valid}, 32'h1);
        check("t5_status", {31'h0, m0_resp_status}, 32'h0);
        check("t5_rdata", m0_resp_rdata, 32'hCAFEF00D);
        tick();

        // reset during a request abandons it; next tie goes to m0
        m0_req_valid = 1'b1; m0_req_op = 2'b01; m0_req_address = 32'h700;
        tick();
        m0_req_valid = 1'b0;
        tick();
        check("t6_in_req", {31'h0, c_req_valid}, 32'h1);
        cresetn = 1'b0;
        settle();
        check("t6_creq_drop", {31'h0, c_req_valid}, 32'h0);
        tick();
        cresetn = 1'b1;
        seen = 1'b0;
        c_resp_valid = 1'b1; c_resp_rdata = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | m0_resp_valid | m1_resp_valid | c_req_valid;
        end
        c_resp_valid = 1'b0;
        check("t6_no_resp", {31'h0, seen}, 32'h0);
        m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        settle();
        check("t6_tie_m0", {30'h0, m1_req_ready, m0_req_ready}, 32'h1);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
